fetch_ctrl: RTL and testbench

Instruction fetch and decode controller for the 8-bit CPU. It sits directly downstream of the program counter: it reads `pc`, fetches the instruction word at that address through a ready/request memory handshake, and latches it in an instruction register. It then drives the counter's `stop`, `pcJMP`, `banEBL`, `ban` and `data_in` controls, plus execute strobes to the datapath. It also detects halt, illegal opcodes and memory timeouts.

---
 rtl/fetch_ctrl.sv | 146 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Instruction fetch/decode controller: fetches the word at pc through a
// ready/request handshake, latches it in ir and drives the counter controls.
module fetch_ctrl #(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [7:0]  pc_i,
  input  logic        zero_flag_i,
  output logic [7:0]  mem_addr_o,
  output logic        mem_req_o,
  input  logic        mem_ready_i,
  input  logic [15:0] mem_rdata_i,
  output logic        stop_o,
  output logic        pcJMP_o,
  output logic        banEBL_o,
  output logic        ban_o,
  output logic [7:0]  data_in_o,
  output logic        exec_valid_o,
  output logic [3:0]  alu_op_o,
  output logic [3:0]  rd_o,
  output logic [7:0]  imm_o,
  output logic        halted_o,
  output logic        fault_o,
  output logic        illegal_o
);

  typedef enum logic [2:0] {
    ST_RST   = 3'd0,
    ST_REQ   = 3'd1,
    ST_EXEC  = 3'd2,
    ST_HALT  = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam logic [7:0] MaxWaitC = 8'(MAX_WAIT);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [7:0]  wait_q, wait_d;
  logic        illegal_q, illegal_d;
  logic [3:0]  opcode_s;
  logic        exec_s;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  assign opcode_s = ir_q[15:12];

  // State, instruction register, wait counter and sticky illegal flag
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_RST;
      ir_q      <= 16'h0000;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ir_q      <= ir_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    ir_d      = ir_q;
    wait_d    = wait_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_RST: begin
        state_d = ST_REQ;
        wait_d  = 8'd0;
      end
      ST_REQ: begin
        if (mem_ready_i) begin
          ir_d = mem_rdata_i;
          if (mem_rdata_i[15:12] == 4'hF) begin
            state_d = ST_HALT;
          end else begin
            state_d = ST_EXEC;
          end
        end else begin
          wait_d = wait_q + 8'd1;
          // a ready on the MAX_WAIT-th cycle wins; only its absence faults
          if (wait_d == MaxWaitC) begin
            state_d = ST_FAULT;
          end else begin
            state_d = ST_REQ;
          end
        end
      end
      ST_EXEC: begin
        state_d = ST_REQ;
        wait_d  = 8'd0;
        if (is_illegal(opcode_s)) begin
          illegal_d = 1'b1;
        end else begin
          illegal_d = illegal_q;
        end
      end
      ST_HALT:  state_d = ST_HALT;
      ST_FAULT: state_d = ST_FAULT;
      default:  state_d = ST_RST;
    endcase
  end

  // Decoded outputs; reset also masks EXEC so the counter never moves in reset
  always_comb begin
    exec_s       = (state_q == ST_EXEC) && !rst_i;
    stop_o       = !exec_s;
    mem_req_o    = (state_q == ST_REQ);
    mem_addr_o   = pc_i;
    pcJMP_o      = 1'b0;
    banEBL_o     = 1'b0;
    ban_o        = 1'b0;
    exec_valid_o = 1'b0;
    if (exec_s) begin
      case (opcode_s)
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: exec_valid_o = 1'b1;
        4'h8: pcJMP_o = 1'b1;
        4'h9: begin
          banEBL_o = 1'b1;
          ban_o    = zero_flag_i;
        end
        4'hA: begin
          banEBL_o = 1'b1;
          ban_o    = !zero_flag_i;
        end
        default: exec_valid_o = 1'b0;
      endcase
    end else begin
      exec_valid_o = 1'b0;
    end
    data_in_o = ir_q[7:0];
    alu_op_o  = ir_q[15:12];
    rd_o      = ir_q[11:8];
    imm_o     = ir_q[7:0];
    halted_o  = (state_q == ST_HALT);
    fault_o   = (state_q == ST_FAULT);
    illegal_o = illegal_q;
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: a program-level model predicts every EXEC
// cycle, halt/fault outcome and sticky illegal flag; a monitor compares.
module tb_fetch_ctrl;
  localparam int MAXW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, zero_flag, mem_ready;
  logic [7:0]  pc;
  logic [15:0] mem_rdata;
  logic [7:0]  mem_addr, data_in, imm;
  logic [3:0]  alu_op, rd;
  logic        mem_req, stop, pcJMP, banEBL, ban, exec_valid, halted, fault, illegal;

  fetch_ctrl #(.MAX_WAIT(MAXW)) dut (
    .clk_i(clk), .rst_i(rst), .pc_i(pc), .zero_flag_i(zero_flag),
    .mem_addr_o(mem_addr), .mem_req_o(mem_req), .mem_ready_i(mem_ready),
    .mem_rdata_i(mem_rdata), .stop_o(stop), .pcJMP_o(pcJMP), .banEBL_o(banEBL),
    .ban_o(ban), .data_in_o(data_in), .exec_valid_o(exec_valid), .alu_op_o(alu_op),
    .rd_o(rd), .imm_o(imm), .halted_o(halted), .fault_o(fault), .illegal_o(illegal)
  );

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] word;
    logic        pcjmp, banebl, ban, ev, ill;
    int          period;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mem[256];
  int          waitm[256];
  logic        zfm[256];
  int          tests = 0, fails = 0;
  int          cyc = 0, last_exec = -1, last_req_run = 0;
  bit          checking = 1'b0;
  bit          exp_halt, exp_fault;
  logic [7:0]  exp_end_pc;
  logic        exp_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Environment: program counter, zero flag and memory responder
  initial begin : env
    int         cnt;
    logic [7:0] pc_nxt;
    cnt = 0;
    pc = 8'h00; zero_flag = 1'b0; mem_ready = 1'b0; mem_rdata = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst) pc_nxt = 8'h00;
      else if (stop) pc_nxt = pc;
      else if (pcJMP) pc_nxt = data_in;
      else if (banEBL && ban) pc_nxt = pc + 8'd1 + data_in;
      else pc_nxt = pc + 8'd1;
      @(posedge clk);
      cyc++;
      #1;
      pc = pc_nxt;
      zero_flag = zfm[pc];
      if (mem_req) begin
        mem_ready = (cnt == waitm[pc]);
        mem_rdata = mem_ready ? mem[pc] : 16'($urandom);
        cnt++;
      end else begin
        if (cnt != 0) last_req_run = cnt;
        cnt = 0;
        mem_ready = 1'b0;
      end
    end
  end

  // Monitor: every EXEC cycle pops one predicted instruction
  initial begin : mon
    exp_t e;
    forever begin
      @(negedge clk);
      if (checking) begin
        if (mem_req) chk("mem_addr", 32'(mem_addr), 32'(pc));
        if (!stop) begin
          if (exp_q.size() == 0) begin
            if (exp_halt || exp_fault) begin
              tests++; fails++;
              $display("FAIL unexpected_exec: got EXEC at pc %0h, expected none", pc);
            end
          end else begin
            e = exp_q.pop_front();
            chk("exec_pc", 32'(pc), 32'(e.pc));
            chk("fields", 32'({alu_op, rd, imm}), 32'(e.word));
            chk("data_in", 32'(data_in), 32'(e.word[7:0]));
            chk("decode", 32'({pcJMP, banEBL, ban, exec_valid}),
                32'({e.pcjmp, e.banebl, e.ban, e.ev}));
            chk("illegal", 32'(illegal), 32'(e.ill));
            if (e.period >= 0) chk("period", 32'(cyc - last_exec), 32'(e.period));
          end
          last_exec = cyc;
        end
      end
    end
  end

  task automatic fill_default();
    for (int i = 0; i < 256; i++) begin
      mem[i] = 16'hF000; waitm[i] = 0; zfm[i] = 1'b0;
    end
  endtask

  task automatic run_prog(input int maxn, input bit interrupt);
    logic [7:0]  p;
    logic [15:0] w;
    logic [3:0]  op;
    logic        ill;
    exp_t        e;
    int          budget, moved;
    @(posedge clk); #2;
    rst = 1'b1; checking = 1'b0;
    exp_q.delete(); exp_halt = 1'b0; exp_fault = 1'b0;
    p = 8'h00; ill = 1'b0;
    for (int n = 0; n < maxn; n++) begin
      if (waitm[p] >= MAXW) begin exp_fault = 1'b1; break; end
      w = mem[p]; op = w[15:12];
      if (op == 4'hF) begin exp_halt = 1'b1; break; end
      e.pc = p; e.word = w;
      e.pcjmp  = (op == 4'h8);
      e.banebl = (op == 4'h9) || (op == 4'hA);
      e.ban    = ((op == 4'h9) && zfm[p]) || ((op == 4'hA) && !zfm[p]);
      e.ev     = (op >= 4'h1) && (op <= 4'h7);
      e.ill    = ill;
      e.period = (n == 0) ? -1 : waitm[p] + 2;
      exp_q.push_back(e);
      if (op >= 4'hB && op <= 4'hE) ill = 1'b1;
      if (e.pcjmp) p = w[7:0];
      else if (e.ban) p = p + 8'd1 + w[7:0];
      else p = p + 8'd1;
    end
    exp_end_pc = p; exp_ill = ill;
    @(posedge clk); #2;
    @(negedge clk);
    chk("reset_flags", 32'({stop, mem_req, pcJMP, banEBL, ban, exec_valid, halted, fault, illegal}),
        32'(9'b100000000));
    chk("reset_ir", 32'({data_in, alu_op, rd, imm}), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0; last_exec = -1; checking = 1'b1;
    budget = 3000;
    while (budget > 0) begin
      @(negedge clk); #1;
      budget--;
      if (interrupt) begin
        if (illegal && mem_req) break;
      end else if (exp_fault) begin
        if (fault) break;
      end else if (exp_halt) begin
        if (halted) break;
      end else begin
        if (exp_q.size() == 0) break;
      end
    end
    if (budget == 0) begin
      tests++; fails++;
      $display("FAIL timeout: got no completion, expected one within 3000 cycles");
    end else if (interrupt) begin
      checking = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("rst_midreq", 32'({mem_req, illegal, stop}), 32'(3'b001));
    end else if (exp_halt || exp_fault) begin
      chk("leftover", 32'(exp_q.size()), 32'd0);
      chk("end_flags", 32'({halted, fault, mem_req, stop}), 32'({exp_halt, exp_fault, 2'b01}));
      chk("end_pc", 32'(pc), 32'(exp_end_pc));
      chk("end_illegal", 32'(illegal), 32'(exp_ill));
      if (exp_fault) chk("fault_req_cycles", 32'(last_req_run), 32'(MAXW));
      moved = 0;
      repeat (20) begin
        @(negedge clk);
        if (pc != exp_end_pc || !stop) moved++;
      end
      chk("frozen", 32'(moved), 32'd0);
    end
    checking = 1'b0;
  endtask

  initial begin : main
    rst = 1'b1;
    fill_default();
    mem[8'h00] = 16'h1305; mem[8'h01] = 16'h0000; mem[8'h02] = 16'h8040;
    mem[8'h40] = 16'h8010;
    mem[8'h10] = 16'h90FC; zfm[8'h10] = 1'b1;
    mem[8'h0D] = 16'hA0FC; zfm[8'h0D] = 1'b1;
    mem[8'h0E] = 16'h90FC;
    mem[8'h0F] = 16'hA002;
    mem[8'h12] = 16'hC0AA; waitm[8'h12] = MAXW - 1;
    mem[8'h13] = 16'h1000; waitm[8'h13] = 3;
    run_prog(100, 1'b0);
    chk("halt_addr", 32'(exp_end_pc), 32'h14);

    fill_default();
    mem[8'h00] = 16'h1111; mem[8'h01] = 16'h2222; waitm[8'h01] = 255;
    run_prog(100, 1'b0);

    fill_default();
    mem[8'h00] = 16'hC0AA; waitm[8'h01] = 8;
    run_prog(100, 1'b1);

    repeat (8) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]   = 16'($urandom);
        waitm[i] = ($urandom_range(0, 15) == 0) ? MAXW - 1 : $urandom_range(0, 3);
        if ($urandom_range(0, 63) == 0) waitm[i] = MAXW;
        zfm[i]   = 1'($urandom_range(0, 1));
      end
      run_prog(40, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
